// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and helpers
// for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 32;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/halfadder.sv
// halfadder: 1-bit half adder,
// sum and carry of two bits.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: 1-bit full adder built
// from two half adders and an OR for carry.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic s0;
  logic c0;
  logic c1;

  halfadder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  halfadder u_ha1 (
    .a_i (s0),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c1)
  );

  assign co_o = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial add
// of two WIDTH-bit operands on one FA cell.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  // Only the upper WIDTH-1 result bits need
  // storing; the newest bit comes from the cell.
  logic [WIDTH-2:0] ps_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             s;
  logic             co;
  logic [WIDTH-1:0] sum_d;

  serial_fa_cell u_cell (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .c_i  (c_q),
    .s_o  (s),
    .co_o (co)
  );

  // Partial sum including this cycle's bit.
  assign sum_d = {s, ps_q};

  // Sequencer: load, shift, recirculate carry,
  // and publish the result on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            a_q     <= a_in;
            b_q     <= b_in;
            c_q     <= cin;
            cnt_q   <= '0;
            ps_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= co;
          ps_q  <= sum_d[WIDTH-1:1];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            sum_q   <= sum_d;
            cout_q  <= co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: random and directed
// stimulus against a timeline model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_chk;
  int n_pass;
  bit chk_en;

  // model: age 0 = idle, 1..W = running,
  // W+1 = done cycle
  int         m_age;
  logic [W:0] m_res;
  logic [W:0] m_out;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  // Model advance for one rising edge.
  task automatic model_edge();
    if (rst) begin
      m_age = 0;
      m_out = '0;
    end else if (m_age == 0) begin
      if (start) begin
        m_age = 1;
        m_res = {1'b0, a_in} + {1'b0, b_in}
              + {{W{1'b0}}, cin};
      end
    end else if (m_age == W + 1) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == W + 1) m_out = m_res;
    end
  endtask

  // Drive one cycle's inputs, clock it,
  // then return at the following negedge.
  task automatic tick(input logic r,
                      input logic s,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic ci);
    rst   = r;
    start = s;
    a_in  = a;
    b_in  = b;
    cin   = ci;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy),
          32'(m_age >= 1 && m_age <= W));
      chk("done", 32'(done), 32'(m_age == W + 1));
      chk("sum", 32'(sum), 32'(m_out[W-1:0]));
      chk("cout", 32'(cout), 32'(m_out[W]));
    end
  end

  // Start one op, then wait (bounded) for done;
  // check latency and the literal result.
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic ci,
                        input logic [W:0] exp,
                        input string nm);
    int at;
    at = -1;
    tick(0, 1, a, b, ci);
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, $urandom, $urandom, $urandom);
      if (done && at < 0) begin
        at = i;
        chk({nm, "_val"}, 32'({cout, sum}),
            32'(exp));
      end
    end
    chk({nm, "_lat"}, 32'(at), 32'(W - 1));
  endtask

  initial begin
    int ndone;
    n_chk  = 0;
    n_pass = 0;
    chk_en = 0;
    m_age  = 0;
    m_res  = '0;
    m_out  = '0;
    rst = 1; start = 0;
    a_in = '0; b_in = '0; cin = 0;
    @(negedge clk);
    tick(1, 1, 8'hFF, 8'hFF, 1);
    chk_en = 1;
    tick(1, 0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum", 32'({cout, sum}), 0);

    run_op(8'h00, 8'h00, 0, 9'h000, "zero");
    run_op(8'hFF, 8'h01, 0, 9'h100, "ripple");
    run_op(8'hA5, 8'h5A, 1, 9'h100, "a5_5a");
    run_op(8'h12, 8'h34, 0, 9'h046, "12_34");
    tick(0, 0, 8'hEE, 8'hEE, 1);
    chk("hold", 32'({cout, sum}), 32'(9'h046));

    // starts in cycle 3 and DONE cycle ignored
    for (int k = 0; k < 12; k++) begin
      if (k == 0) tick(0, 1, 8'h10, 8'h20, 0);
      else tick(0, (k == 3 || k == 9),
                8'hFF, 8'hFF, 1);
      if (k == 8) begin
        chk("ign_done", 32'(done), 1);
        chk("ign_val", 32'({cout, sum}),
            32'(9'h030));
      end
    end

    // reset in cycle 4 of a run
    for (int k = 0; k < 14; k++) begin
      tick(k == 4, k == 0, 8'h77, 8'h99, 1);
      if (k == 4)
        chk("abort", 32'({busy, done, cout, sum}),
            0);
    end
    run_op(8'h03, 8'h04, 0, 9'h007, "after_rst");

    // start held high: one op per W+2 cycles
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick(0, 1, $urandom, $urandom, $urandom);
      if (done) ndone++;
    end
    chk("held_cnt", 32'(ndone), 4);
    for (int k = 0; k < 12; k++)
      tick(0, 0, 0, 0, 0);

    // random traffic with occasional resets
    for (int k = 0; k < 400; k++)
      tick($urandom_range(0, 49) == 0,
           $urandom_range(0, 2) == 0,
           $urandom, $urandom, $urandom);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
